// File: rtl/d8m_frame_grabber_pkg.sv
// Shared types and helpers for the D8M frame grabber: capture states, SRAM
// write phases, RGB565 packing and the decimation legality check.
package d8m_grab_pkg;

  localparam int ADDR_W = 20;
  localparam int DQ_W   = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARMED,
    ST_CAPTURE,
    ST_DRAIN,
    ST_DONE
  } grab_state_e;

  typedef enum logic [1:0] {
    WP_IDLE = 2'd0,
    WP_W1   = 2'd1,
    WP_W2   = 2'd2
  } wr_phase_e;

  function automatic logic [DQ_W-1:0] pack_rgb565(input logic [7:0] r,
                                                  input logic [7:0] g,
                                                  input logic [7:0] b);
    return {r[7:3], g[7:2], b[7:3]};
  endfunction

  function automatic bit decim_ok(input int d);
    return (d == 1) || (d == 2) || (d == 4);
  endfunction

endpackage

// File: rtl/d8m_frame_grabber_if.sv
// Asynchronous SRAM write bus driven by the frame grabber.
interface d8m_frame_grabber_if;
  import d8m_grab_pkg::*;

  logic [ADDR_W-1:0] addr;
  logic [DQ_W-1:0]   dq;
  logic              dq_oe;
  logic              we_n;
  logic              ce_n;
  logic              oe_n;
  logic              lb_n;
  logic              ub_n;

  modport master (output addr, dq, dq_oe, we_n, ce_n, oe_n, lb_n, ub_n);
  modport slave  (input  addr, dq, dq_oe, we_n, ce_n, oe_n, lb_n, ub_n);
endinterface

// File: rtl/d8m_frame_grabber_pix_fifo.sv
// Single-clock show-ahead pixel FIFO; a push into a full FIFO is accepted
// when a pop happens on the same cycle.
module pix_fifo #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              pop,
  output logic [DATA_W-1:0] rd_data,
  output logic              full,
  output logic              empty
);
  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wr_ptr_q, wr_ptr_d;
  logic [AW:0]       rd_ptr_q, rd_ptr_d;
  logic              wr_en, rd_en;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rd_data = mem[rd_ptr_q[AW-1:0]];

  always_comb begin
    rd_en    = pop & ~empty;
    wr_en    = push & (~full | rd_en);
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, wr_en};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, rd_en};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q[AW-1:0]] <= wr_data;
  end
endmodule

// File: rtl/d8m_frame_grabber.sv
// Grabs one decimated RGB565 frame from the VGA-timed pixel stream into
// async SRAM on request; the SRAM write engine runs independently of capture.
module d8m_frame_grabber
  import d8m_grab_pkg::*;
#(
  parameter int               H_ACT      = 640,
  parameter int               V_ACT      = 480,
  parameter int               DECIM      = 2,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 20'h00000,
  parameter int               FIFO_DEPTH = 16
) (
  input  logic                iCLK,
  input  logic                iRST,
  input  logic                iCAPTURE,
  input  logic [7:0]          iR,
  input  logic [7:0]          iG,
  input  logic [7:0]          iB,
  input  logic [15:0]         iX,
  input  logic [15:0]         iY,
  input  logic                iVS,
  output logic                oBUSY,
  output logic                oDONE,
  output logic                oOVERFLOW,
  output logic [ADDR_W-1:0]   oWORDS,
  d8m_frame_grabber_if.master sram
);
  if (!decim_ok(DECIM)) begin : g_bad_decim
    $error("d8m_frame_grabber: DECIM must be 1, 2 or 4");
  end

  localparam logic [15:0]       H_LIM     = 16'(H_ACT);
  localparam logic [15:0]       V_LIM     = 16'(V_ACT);
  localparam logic [15:0]       DEC_MASK  = 16'(DECIM - 1);
  localparam logic [ADDR_W-1:0] FRAME_PIX = ADDR_W'((H_ACT / DECIM) * (V_ACT / DECIM));

  grab_state_e       state_q, state_d;
  wr_phase_e         wp_q, wp_d;
  logic              samp_p1_q, samp_p1_d;
  logic [DQ_W-1:0]   pix_p1_q, pix_p1_d;
  logic              vs_p1_q, vs_p2_q;
  logic [ADDR_W-1:0] samp_cnt_q, samp_cnt_d;
  logic              ovf_q, ovf_d;
  logic [ADDR_W-1:0] words_q, words_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DQ_W-1:0]   dq_q, dq_d;
  logic              vs_fall, push, pop, clear;
  logic              fifo_full, fifo_empty;
  logic [DQ_W-1:0]   fifo_rd_data;

  // Stage p0 -> p1: qualify and pack the incoming pixel
  always_comb begin
    samp_p1_d = (iX < H_LIM) && (iY < V_LIM) &&
                ((iX & DEC_MASK) == 16'd0) && ((iY & DEC_MASK) == 16'd0);
    pix_p1_d  = pack_rgb565(iR, iG, iB);
  end

  pix_fifo #(.DEPTH(FIFO_DEPTH), .DATA_W(DQ_W)) u_fifo (
    .clk     (iCLK),
    .rst     (iRST),
    .push    (push),
    .wr_data (pix_p1_q),
    .pop     (pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_comb begin
    vs_fall    = vs_p2_q & ~vs_p1_q;
    push       = samp_p1_q && (state_q == ST_CAPTURE);
    // Popping during W2 lets back-to-back words take two cycles each
    pop        = ~fifo_empty && (wp_q != WP_W1);
    state_d    = state_q;
    samp_cnt_d = samp_cnt_q;
    ovf_d      = ovf_q;
    clear      = 1'b0;
    case (state_q)
      ST_IDLE: if (iCAPTURE) begin
        state_d    = ST_ARMED;
        samp_cnt_d = '0;
        ovf_d      = 1'b0;
        clear      = 1'b1;
      end
      ST_ARMED: if (vs_fall) state_d = ST_CAPTURE;
      ST_CAPTURE: begin
        if (push) samp_cnt_d = samp_cnt_q + 20'd1;
        if (push && fifo_full && !pop) ovf_d = 1'b1;
        if ((samp_cnt_d == FRAME_PIX) || vs_fall) state_d = ST_DRAIN;
      end
      ST_DRAIN: if (fifo_empty && (wp_q == WP_IDLE)) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    wp_d    = wp_q;
    words_d = words_q;
    addr_d  = addr_q;
    dq_d    = dq_q;
    if (wp_q == WP_W1) wp_d = WP_W2;
    if (wp_q == WP_W2) begin
      wp_d    = WP_IDLE;
      words_d = words_q + 20'd1;
    end
    if (clear) words_d = '0;
    if (pop) begin
      wp_d   = WP_W1;
      addr_d = BASE_ADDR + words_d;
      dq_d   = fifo_rd_data;
    end
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q    <= ST_IDLE;
      wp_q       <= WP_IDLE;
      samp_p1_q  <= 1'b0;
      vs_p1_q    <= 1'b1;
      vs_p2_q    <= 1'b1;
      samp_cnt_q <= '0;
      ovf_q      <= 1'b0;
      words_q    <= '0;
      addr_q     <= '0;
      dq_q       <= '0;
    end else begin
      state_q    <= state_d;
      wp_q       <= wp_d;
      samp_p1_q  <= samp_p1_d;
      vs_p1_q    <= iVS;
      vs_p2_q    <= vs_p1_q;
      samp_cnt_q <= samp_cnt_d;
      ovf_q      <= ovf_d;
      words_q    <= words_d;
      addr_q     <= addr_d;
      dq_q       <= dq_d;
    end
  end

  always_ff @(posedge iCLK) begin
    pix_p1_q <= pix_p1_d;
  end

  assign oBUSY      = (state_q == ST_ARMED) || (state_q == ST_CAPTURE) || (state_q == ST_DRAIN);
  assign oDONE      = (state_q == ST_DONE);
  assign oOVERFLOW  = ovf_q;
  assign oWORDS     = words_q;
  assign sram.addr  = addr_q;
  assign sram.dq    = dq_q;
  assign sram.we_n  = (wp_q != WP_W1);
  assign sram.ce_n  = (wp_q == WP_IDLE);
  assign sram.lb_n  = (wp_q == WP_IDLE);
  assign sram.ub_n  = (wp_q == WP_IDLE);
  assign sram.dq_oe = (wp_q != WP_IDLE);
  assign sram.oe_n  = 1'b1;
endmodule

// File: tb/tb_d8m_frame_grabber.sv
// Bench for d8m_frame_grabber on a scaled 24x12 raster (16x8 active).
module tb_d8m_frame_grabber;
  localparam int H_ACT = 16, V_ACT = 8, H_TOT = 24, V_TOT = 12, VS_LINE = 10;
  localparam logic [19:0] BASE = 20'h00040;
  localparam int NPIX = (H_ACT / 2) * (V_ACT / 2);

  logic clk = 1'b0, rst = 1'b1, cap0 = 1'b0, cap1 = 1'b0;
  logic [7:0]  r = '0, g = '0, b = '0;
  logic [15:0] x_in = '0, y_in = '0;
  logic        vs = 1'b1;
  logic        busy0, done0, ovf0, busy1, done1, ovf1;
  logic [19:0] words0, words1;

  d8m_frame_grabber_if sram0();
  d8m_frame_grabber_if sram1();

  d8m_frame_grabber #(.H_ACT(H_ACT), .V_ACT(V_ACT), .DECIM(2), .BASE_ADDR(BASE), .FIFO_DEPTH(4)) dut0 (
    .iCLK(clk), .iRST(rst), .iCAPTURE(cap0), .iR(r), .iG(g), .iB(b), .iX(x_in), .iY(y_in), .iVS(vs),
    .oBUSY(busy0), .oDONE(done0), .oOVERFLOW(ovf0), .oWORDS(words0), .sram(sram0));

  d8m_frame_grabber #(.H_ACT(H_ACT), .V_ACT(V_ACT), .DECIM(1), .BASE_ADDR(20'h00000), .FIFO_DEPTH(8)) dut1 (
    .iCLK(clk), .iRST(rst), .iCAPTURE(cap1), .iR(r), .iG(g), .iB(b), .iX(x_in), .iY(y_in), .iVS(vs),
    .oBUSY(busy1), .oDONE(done1), .oOVERFLOW(ovf1), .oWORDS(words1), .sram(sram1));

  int n_checks = 0, n_fail = 0;
  int done_cnt0 = 0, done_cnt1 = 0, bus_err = 0;
  bit mode = 1'b0, short_frame = 1'b0;
  int cx = 0, cy = 0;
  logic [19:0] obs_addr[$], exp_addr[$];
  logic [15:0] obs_data[$], exp_data[$];

  initial forever #5 clk = ~clk;

  // Raster generator: mode 0 constant colour, mode 1 colour encodes coordinates
  initial begin
    forever begin
      @(negedge clk);
      x_in = 16'(cx);
      y_in = 16'(cy);
      vs   = (cy != VS_LINE);
      if (!mode) begin
        r = 8'hFF; g = 8'h80; b = 8'h01;
      end else begin
        r = 8'((cx & 31) << 3); g = 8'((cy & 63) << 2); b = 8'h00;
      end
      cx++;
      if (cx == H_TOT) begin
        cx = 0;
        cy++;
        if (short_frame && cy == 4) cy = VS_LINE;
        if (cy == V_TOT) cy = 0;
      end
    end
  end

  // Write monitor for dut0 plus oDONE pulse counters
  initial begin
    forever begin
      @(negedge clk);
      if (!sram0.we_n) begin
        obs_addr.push_back(sram0.addr);
        obs_data.push_back(sram0.dq);
        if (sram0.ce_n || !sram0.dq_oe || sram0.lb_n || sram0.ub_n || !sram0.oe_n) bus_err++;
      end
      if (done0) done_cnt0++;
      if (done1) done_cnt1++;
    end
  end

  task automatic build_exp(input bit coord, input int lines);
    int idx = 0;
    exp_addr.delete(); exp_data.delete(); obs_addr.delete(); obs_data.delete();
    for (int yy = 0; yy < lines; yy += 2)
      for (int xx = 0; xx < H_ACT; xx += 2) begin
        exp_addr.push_back(BASE + 20'(idx));
        exp_data.push_back(coord ? 16'(((xx & 31) << 11) | ((yy & 63) << 5)) : 16'hFC00);
        idx++;
      end
  endtask

  task automatic pulse(input bit which);
    @(negedge clk);
    if (which) cap1 = 1'b1; else cap0 = 1'b1;
    @(negedge clk);
    cap0 = 1'b0; cap1 = 1'b0;
  endtask

  task automatic wait_done(input bit which, input int d, input int limit, output bit ok);
    int t = 0;
    while (((which ? done_cnt1 : done_cnt0) == d) && t < limit) begin
      @(negedge clk);
      t++;
    end
    ok = ((which ? done_cnt1 : done_cnt0) != d);
  endtask

  task automatic test_reset();
    logic [8:0] ctl;
    repeat (3) @(negedge clk);
    ctl = {busy0, done0, ovf0, sram0.dq_oe, sram0.we_n, sram0.ce_n, sram0.oe_n, sram0.lb_n, sram0.ub_n};
    n_checks++; if (ctl !== 9'b000011111) begin n_fail++; $display("FAIL reset_ctl: got %b want 000011111", ctl); end
    n_checks++; if (words0 !== 20'd0) begin n_fail++; $display("FAIL reset_words: got %h want 0", words0); end
    n_checks++; if (sram0.addr !== 20'd0 || sram0.dq !== 16'd0) begin n_fail++;
      $display("FAIL reset_bus: got addr %h dq %h want 0 0", sram0.addr, sram0.dq); end
    n_checks++; if ({busy1, done1, ovf1} !== 3'b000) begin n_fail++; $display("FAIL reset_dut1: got %b want 000", {busy1, done1, ovf1}); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_full_frame();
    int d; bit ok; logic [19:0] ea, oa; logic [15:0] ed, od;
    mode = 1'b0;
    build_exp(1'b0, V_ACT);
    d = done_cnt0; bus_err = 0;
    pulse(1'b0);
    n_checks++; if (busy0 !== 1'b1) begin n_fail++; $display("FAIL ff_busy: got %b want 1", busy0); end
    wait_done(1'b0, d, 1500, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL ff_timeout: no oDONE within 1500 cycles"); end
    n_checks++; if (obs_data.size() != exp_data.size()) begin n_fail++;
      $display("FAIL ff_count: got %0d writes want %0d", obs_data.size(), exp_data.size()); end
    while (exp_data.size() > 0 && obs_data.size() > 0) begin
      ea = exp_addr.pop_front(); ed = exp_data.pop_front(); oa = obs_addr.pop_front(); od = obs_data.pop_front();
      n_checks++; if (oa !== ea || od !== ed) begin n_fail++;
        $display("FAIL ff_word: got addr %h data %h want addr %h data %h", oa, od, ea, ed); end
    end
    n_checks++; if (words0 !== 20'(NPIX)) begin n_fail++; $display("FAIL ff_words: got %0d want %0d", words0, NPIX); end
    n_checks++; if (ovf0 !== 1'b0 || busy0 !== 1'b0) begin n_fail++; $display("FAIL ff_flags: got ovf %b busy %b want 0 0", ovf0, busy0); end
    n_checks++; if (bus_err != 0) begin n_fail++; $display("FAIL ff_bus_ctl: got %0d bad W1 cycles want 0", bus_err); end
    n_checks++; if (done_cnt0 != d + 1) begin n_fail++; $display("FAIL ff_done_cnt: got %0d want %0d", done_cnt0 - d, 1); end
  endtask

  task automatic test_midframe();
    int d, t; bit ok; logic [19:0] ea, oa; logic [15:0] ed, od;
    mode = 1'b1;
    t = 0;
    while (!(cy == 3 && cx == 5) && t < 400) begin @(negedge clk); t++; end
    build_exp(1'b1, V_ACT);
    d = done_cnt0;
    pulse(1'b0);
    t = 0;
    while (cy != VS_LINE && t < 400) begin @(negedge clk); t++; end
    n_checks++; if (obs_data.size() != 0) begin n_fail++; $display("FAIL mid_early_write: got %0d writes before VS want 0", obs_data.size()); end
    wait_done(1'b0, d, 1500, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL mid_timeout: no oDONE within 1500 cycles"); end
    n_checks++; if (obs_data.size() != exp_data.size()) begin n_fail++;
      $display("FAIL mid_count: got %0d writes want %0d", obs_data.size(), exp_data.size()); end
    while (exp_data.size() > 0 && obs_data.size() > 0) begin
      ea = exp_addr.pop_front(); ed = exp_data.pop_front(); oa = obs_addr.pop_front(); od = obs_data.pop_front();
      n_checks++; if (oa !== ea || od !== ed) begin n_fail++;
        $display("FAIL mid_word: got addr %h data %h want addr %h data %h", oa, od, ea, ed); end
    end
  endtask

  task automatic test_capture_while_busy();
    int d; bit ok;
    mode = 1'b0;
    d = done_cnt0;
    pulse(1'b0);
    repeat (20) @(negedge clk);
    n_checks++; if (busy0 !== 1'b1) begin n_fail++; $display("FAIL busy_armed: got %b want 1", busy0); end
    pulse(1'b0);
    wait_done(1'b0, d, 1500, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL busy_timeout: no oDONE within 1500 cycles"); end
    repeat (350) @(negedge clk);
    n_checks++; if (done_cnt0 != d + 1) begin n_fail++; $display("FAIL busy_done_cnt: got %0d want 1", done_cnt0 - d); end
    n_checks++; if (busy0 !== 1'b0 || words0 !== 20'(NPIX)) begin n_fail++;
      $display("FAIL busy_final: got busy %b words %0d want 0 %0d", busy0, words0, NPIX); end
  endtask

  task automatic test_early_vs();
    int d; bit ok; logic [19:0] ea, oa; logic [15:0] ed, od;
    mode = 1'b1;
    short_frame = 1'b1;
    build_exp(1'b1, 4);
    d = done_cnt0;
    pulse(1'b0);
    wait_done(1'b0, d, 1500, ok);
    short_frame = 1'b0;
    n_checks++; if (!ok) begin n_fail++; $display("FAIL early_timeout: no oDONE within 1500 cycles"); end
    n_checks++; if (words0 !== 20'(NPIX / 2)) begin n_fail++; $display("FAIL early_words: got %0d want %0d", words0, NPIX / 2); end
    n_checks++; if (obs_data.size() != exp_data.size()) begin n_fail++;
      $display("FAIL early_count: got %0d writes want %0d", obs_data.size(), exp_data.size()); end
    while (exp_data.size() > 0 && obs_data.size() > 0) begin
      ea = exp_addr.pop_front(); ed = exp_data.pop_front(); oa = obs_addr.pop_front(); od = obs_data.pop_front();
      n_checks++; if (oa !== ea || od !== ed) begin n_fail++;
        $display("FAIL early_word: got addr %h data %h want addr %h data %h", oa, od, ea, ed); end
    end
  endtask

  task automatic test_overflow();
    int d; bit ok;
    mode = 1'b1;
    d = done_cnt1;
    pulse(1'b1);
    wait_done(1'b1, d, 1500, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL ovf_timeout: no oDONE within 1500 cycles"); end
    n_checks++; if (ovf1 !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b want 1", ovf1); end
    n_checks++; if (words1 >= 20'(H_ACT * V_ACT) || words1 == 20'd0) begin n_fail++;
      $display("FAIL ovf_words: got %0d want 1..%0d", words1, H_ACT * V_ACT - 1); end
    n_checks++; if (busy1 !== 1'b0) begin n_fail++; $display("FAIL ovf_busy: got %b want 0", busy1); end
    pulse(1'b1);
    n_checks++; if (ovf1 !== 1'b0 || words1 !== 20'd0 || busy1 !== 1'b1) begin n_fail++;
      $display("FAIL ovf_rearm: got ovf %b words %0d busy %b want 0 0 1", ovf1, words1, busy1); end
    d = done_cnt1;
    wait_done(1'b1, d, 1500, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL ovf_timeout2: no oDONE within 1500 cycles"); end
  endtask

  task automatic test_reset_during_write();
    int d, t; bit ok; logic [19:0] ea, oa; logic [15:0] ed, od;
    mode = 1'b1;
    pulse(1'b0);
    t = 0;
    while (sram0.we_n && t < 1000) begin @(negedge clk); t++; end
    n_checks++; if (sram0.we_n !== 1'b0) begin n_fail++; $display("FAIL rst_w1_seen: got we_n %b want 0", sram0.we_n); end
    #1 rst = 1'b1;
    #1;
    n_checks++; if ({sram0.we_n, sram0.dq_oe, sram0.ce_n, busy0} !== 4'b1010) begin n_fail++;
      $display("FAIL rst_async: got we_n/dq_oe/ce_n/busy %b want 1010", {sram0.we_n, sram0.dq_oe, sram0.ce_n, busy0}); end
    @(negedge clk);
    rst = 1'b0;
    d = done_cnt0;
    repeat (20) @(negedge clk);
    n_checks++; if (done_cnt0 != d || busy0 !== 1'b0 || words0 !== 20'd0) begin n_fail++;
      $display("FAIL rst_idle: got dones %0d busy %b words %0d want 0 0 0", done_cnt0 - d, busy0, words0); end
    build_exp(1'b1, V_ACT);
    pulse(1'b0);
    wait_done(1'b0, d, 1500, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL rst_timeout: no oDONE within 1500 cycles"); end
    n_checks++; if (obs_data.size() != exp_data.size()) begin n_fail++;
      $display("FAIL rst_count: got %0d writes want %0d", obs_data.size(), exp_data.size()); end
    while (exp_data.size() > 0 && obs_data.size() > 0) begin
      ea = exp_addr.pop_front(); ed = exp_data.pop_front(); oa = obs_addr.pop_front(); od = obs_data.pop_front();
      n_checks++; if (oa !== ea || od !== ed) begin n_fail++;
        $display("FAIL rst_word: got addr %h data %h want addr %h data %h", oa, od, ea, ed); end
    end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_midframe();
    test_capture_while_busy();
    test_early_vs();
    test_overflow();
    test_reset_during_write();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
